i_buffer_feeder: RTL and testbench

Input-side counterpart of the output buffer. The host loads operand rows into ARRAY_M single-lane BRAM banks. On `start`, the block reads a block of rows back out and drives them into the systolic array's edge as one `data_set_out` word per cycle. In WS mode each lane is time-skewed, so lane c lags lane 0 by c cycles; this is the inverse of the de-skew the output buffer performs. In OS mode all lanes are presented aligned.

---
 rtl/i_buffer_feeder.sv | 207 ++++++++++++++++++++
 tb/tb_i_buffer_feeder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i_buffer_feeder.sv
// Input-side feeder: ARRAY_M single-lane BRAM banks read back row by row and
// driven into the array edge, time-skewed per lane (WS) or aligned (OS).
module i_buffer_feeder #(
  parameter int RAM_SIZE       = 256,
  parameter int ADDR_WIDTH     = $clog2(RAM_SIZE),
  parameter int ARRAY_M        = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_SET_WIDTH = ARRAY_M * DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(ARRAY_M)-1:0] wr_idx,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [ADDR_WIDTH:0]        depth,
  input  logic [$clog2(ARRAY_M):0]   num_cols,
  input  logic                       mode,
  output logic [DATA_SET_WIDTH-1:0]  data_set_out,
  output logic                       valid_out,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = $clog2(ARRAY_M);
  localparam int COL_W = IDX_W + 1;
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     base_q, base_d;
  logic [CNT_W-1:0]          depth_q, depth_d;
  logic [COL_W-1:0]          ncols_q, ncols_d;
  logic                      mode_q, mode_d;
  logic [ARRAY_M-1:0]        lane_en_q, lane_en_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      valid_q, valid_d;
  logic [DATA_SET_WIDTH-1:0] data_q, data_d;

  logic [COL_W-1:0]          ncols_in;
  logic [ARRAY_M-1:0]        lane_mask;
  logic                      flush_last;
  logic                      rd_en;
  logic [ADDR_WIDTH-1:0]     rd_addr;

  logic [DATA_WIDTH-1:0]     bank_rd [ARRAY_M];
  logic [DATA_WIDTH-1:0]     lane_in [ARRAY_M];
  logic [DATA_WIDTH-1:0]     ws_in   [ARRAY_M];
  logic [DATA_WIDTH-1:0]     tail    [ARRAY_M];
  logic [ARRAY_M-1:0]        lane_v, ws_v, tail_v;

  // Out-of-range lane counts fall back to the full array width.
  always_comb begin
    ncols_in = num_cols;
    if (num_cols == '0 || num_cols > COL_W'(ARRAY_M)) ncols_in = COL_W'(ARRAY_M);
    lane_mask = '0;
    for (int c = 0; c < ARRAY_M; c++) lane_mask[c] = (COL_W'(c) < ncols_in);
  end

  assign flush_last = mode_q ? (cnt_q == '0) : (cnt_q == CNT_W'(ncols_q) - CNT_W'(1));
  assign rd_en      = (state_q == READ);
  assign rd_addr    = base_q + cnt_q[ADDR_WIDTH-1:0];

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    depth_d    = depth_q;
    ncols_d    = ncols_q;
    mode_d     = mode_q;
    lane_en_d  = lane_en_q;
    rd_valid_d = (state_q == READ);
    busy_d     = (state_q != IDLE);
    done_d     = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d    = base_addr;
          depth_d   = depth;
          ncols_d   = ncols_in;
          mode_d    = mode;
          lane_en_d = lane_mask;
          cnt_d     = '0;
          state_d   = (depth == '0) ? DONE : READ;
        end
      end
      READ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == depth_q - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank outputs are only meaningful while rd_valid_q; inactive lanes are forced to zero.
  always_comb begin
    for (int c = 0; c < ARRAY_M; c++) begin
      lane_v[c]  = rd_valid_q & lane_en_q[c];
      ws_v[c]    = lane_v[c] & ~mode_q;
      lane_in[c] = lane_v[c] ? bank_rd[c] : '0;
      ws_in[c]   = ws_v[c] ? bank_rd[c] : '0;
    end
  end

  always_comb begin
    data_d = '0;
    for (int c = 0; c < ARRAY_M; c++)
      data_d[DATA_WIDTH*c +: DATA_WIDTH] = mode_q ? lane_in[c] : tail[c];
    valid_d = mode_q ? rd_valid_q : |tail_v;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      depth_q    <= '0;
      ncols_q    <= '0;
      mode_q     <= 1'b0;
      lane_en_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      depth_q    <= depth_d;
      ncols_q    <= ncols_d;
      mode_q     <= mode_d;
      lane_en_q  <= lane_en_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  for (genvar c = 0; c < ARRAY_M; c++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];
    logic [DATA_WIDTH-1:0] rd_q;

    // NOTE: the bank array has no reset so it maps onto block RAM and survives reset.
    always_ff @(posedge clk) begin
      if (wr_en && wr_idx == IDX_W'(c)) mem[wr_addr] <= wr_data;
      if (rd_en) rd_q <= mem[rd_addr];
    end
    assign bank_rd[c] = rd_q;

    if (c == 0) begin : g_noskew
      assign tail[c]   = ws_in[c];
      assign tail_v[c] = ws_v[c];
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] dly_q [c];
      logic [DATA_WIDTH-1:0] dly_d [c];
      logic [c-1:0]          vld_q, vld_d;

      always_comb begin
        dly_d[0] = ws_in[c];
        vld_d    = '0;
        vld_d[0] = ws_v[c];
        for (int s = 1; s < c; s++) begin
          dly_d[s] = dly_q[s-1];
          vld_d[s] = vld_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int s = 0; s < c; s++) dly_q[s] <= '0;
          vld_q <= '0;
        end else begin
          dly_q <= dly_d;
          vld_q <= vld_d;
        end
      end

      assign tail[c]   = dly_q[c-1];
      assign tail_v[c] = vld_q[c-1];
    end
  end

  assign data_set_out = data_q;
  assign valid_out    = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_i_buffer_feeder.sv
// Directed bench for i_buffer_feeder; expectations come from a bench-side
// image of the banks and the cycle formulas for WS/OS streaming.
module tb_i_buffer_feeder;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [2:0]   wr_idx;
  logic [7:0]   wr_addr;
  logic [31:0]  wr_data;
  logic         start;
  logic [7:0]   base_addr;
  logic [8:0]   depth;
  logic [3:0]   num_cols;
  logic         mode;
  logic [255:0] data_set_out;
  logic         valid_out;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [8][256];

  i_buffer_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .base_addr    (base_addr),
    .depth        (depth),
    .num_cols     (num_cols),
    .mode         (mode),
    .data_set_out (data_set_out),
    .valid_out    (valid_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int b, input int a, input logic [31:0] v);
    wr_en   = 1'b1;
    wr_idx  = 3'(b);
    wr_addr = 8'(a);
    wr_data = v;
    step();
    wr_en = 1'b0;
    mdl[b][a] = v;
  endtask

  function automatic logic [31:0] exp_lane(input int c, input int k, input int base,
                                           input int d, input int n, input logic os);
    int r;
    if (c >= n) return 32'h0;
    r = os ? k : k - c;
    if (r < 0 || r >= d) return 32'h0;
    return mdl[c][(base + r) % 256];
  endfunction

  task automatic check_idle_outputs(input string name);
    tests++;
    if (data_set_out !== 256'h0) begin
      fails++;
      $display("FAIL %s data got %h exp 0", name, data_set_out);
    end
    tests++;
    if ({valid_out, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL %s valid/busy/done got %b exp 000", name, {valid_out, busy, done});
    end
  endtask

  // Launches one operation and checks every output on every cycle through done+2.
  task automatic run_stream(input string name, input int base, input int d, input int ncols,
                            input logic os, input int poke_t, input int coll_t,
                            input int coll_bank, input logic [31:0] coll_val);
    int n, vlen, done_t, k;
    logic [255:0] exp_d;
    logic exp_v, exp_done, exp_busy;
    n      = (ncols == 0 || ncols > 8) ? 8 : ncols;
    vlen   = (d == 0) ? 0 : (os ? d : d + n - 1);
    done_t = (d == 0) ? 1 : vlen + 2;
    base_addr = 8'(base);
    depth     = 9'(d);
    num_cols  = 4'(ncols);
    mode      = os;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= done_t + 2; t++) begin
      step();
      start = 1'b0;
      wr_en = 1'b0;
      k = t - 2;
      for (int c = 0; c < 8; c++) exp_d[c*32 +: 32] = exp_lane(c, k, base, d, n, os);
      exp_v    = (k >= 0) && (k < vlen);
      exp_done = (t == done_t);
      exp_busy = (t <= done_t);
      tests++;
      if (data_set_out !== exp_d) begin
        fails++;
        $display("FAIL %s data t=%0d got %h exp %h", name, t, data_set_out, exp_d);
      end
      tests++;
      if (valid_out !== exp_v) begin
        fails++;
        $display("FAIL %s valid t=%0d got %b exp %b", name, t, valid_out, exp_v);
      end
      tests++;
      if (done !== exp_done) begin
        fails++;
        $display("FAIL %s done t=%0d got %b exp %b", name, t, done, exp_done);
      end
      tests++;
      if (busy !== exp_busy) begin
        fails++;
        $display("FAIL %s busy t=%0d got %b exp %b", name, t, busy, exp_busy);
      end
      if (t == poke_t) begin
        start     = 1'b1;
        base_addr = 8'd0;
        depth     = 9'd2;
        num_cols  = 4'd1;
        mode      = ~os;
      end
      if (t == coll_t) begin
        wr_en   = 1'b1;
        wr_idx  = 3'(coll_bank);
        wr_addr = 8'((base + coll_t) % 256);
        wr_data = coll_val;
      end
    end
    if (coll_t >= 0) mdl[coll_bank][(base + coll_t) % 256] = coll_val;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    reset = 1'b1;
    step();
    check_idle_outputs("post_reset");
  endtask

  task automatic test_ws_full();
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) host_write(c, 128 + r, 32'(r + 1));
    run_stream("ws_full", 128, 8, 8, 1'b0, -1, -1, 0, 32'h0);
  endtask

  task automatic test_os();
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) host_write(c, r, 32'(16 + r));
    run_stream("os", 0, 8, 8, 1'b1, -1, -1, 0, 32'h0);
  endtask

  task automatic test_partial_wrap();
    int addrs [4] = '{254, 255, 0, 1};
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 4; r++) host_write(c, addrs[r], 32'hA000 + 32'(c * 16 + r));
    run_stream("partial_wrap", 254, 4, 3, 1'b0, -1, -1, 0, 32'h0);
    run_stream("cols_zero_clamp", 128, 3, 0, 1'b0, -1, -1, 0, 32'h0);
    run_stream("cols_over_clamp", 254, 4, 12, 1'b1, -1, -1, 0, 32'h0);
  endtask

  task automatic test_depth_zero();
    run_stream("depth_zero", 5, 0, 8, 1'b0, -1, -1, 0, 32'h0);
  endtask

  task automatic test_start_busy();
    run_stream("start_busy", 128, 8, 8, 1'b0, 3, -1, 0, 32'h0);
  endtask

  task automatic test_collision();
    run_stream("collide_old", 128, 8, 8, 1'b1, -1, 2, 5, 32'hDEADBEEF);
    run_stream("collide_new", 128, 8, 8, 1'b1, -1, -1, 0, 32'h0);
  endtask

  task automatic test_reset_mid();
    base_addr = 8'd128;
    depth     = 9'd8;
    num_cols  = 4'd8;
    mode      = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 5; t++) step();
    tests++;
    if (data_set_out !== {32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h4}) begin
      fails++;
      $display("FAIL reset_mid pre-reset data got %h", data_set_out);
    end
    reset = 1'b0;
    step();
    check_idle_outputs("reset_mid");
    reset = 1'b1;
    step();
    check_idle_outputs("reset_mid_idle");
    run_stream("reset_replay", 128, 8, 8, 1'b0, -1, -1, 0, 32'h0);
  endtask

  initial begin
    reset     = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_addr   = '0;
    wr_data   = '0;
    start     = 1'b0;
    base_addr = '0;
    depth     = '0;
    num_cols  = '0;
    mode      = 1'b0;
    test_reset();
    test_ws_full();
    test_os();
    test_partial_wrap();
    test_depth_zero();
    test_start_busy();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
